// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types, field widths and constants for the FP32 add/sub engine
// Purpose: FSM state encoding, field/mantissa widths, special-value constants and
//          small helpers shared by fpu_addsub_seq and fpu_align_shift.
// Ports:   none (package).
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int GRS_W  = 3;
    // Internal mantissa: [MW-1] carry, [MW-2] hidden bit, fraction, then guard/round/sticky.
    localparam int MW     = FRAC_W + 2 + GRS_W;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [31:0]      POS_INF = 32'h7F80_0000;
    localparam logic [31:0]      NEG_INF = 32'hFF80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_HOLD
    } state_t;

    function automatic logic [31:0] signed_inf(input logic sign);
        return sign ? NEG_INF : POS_INF;
    endfunction

    // Denormals are not supported: any zero-exponent operand becomes a signed zero.
    function automatic logic [31:0] flush_denorm(input logic [31:0] x);
        return (x[30:23] == '0) ? {x[31], 31'b0} : x;
    endfunction

endpackage

// File: rtl/fpu_align_shift.sv
// rtl/fpu_align_shift.sv - combinational right barrel shifter with sticky collection
// Purpose: shifts the smaller operand's mantissa right during alignment; every bit
//          shifted out is ORed into the result LSB so rounding still sees it.
// Ports:   din   - unshifted mantissa (MW bits)
//          shamt - right shift amount, 0..27
//          dout  - shifted mantissa with sticky folded into bit 0
module fpu_align_shift
    import fpu_pkg::*;
(
    input  logic [MW-1:0] din,
    input  logic [4:0]    shamt,
    output logic [MW-1:0] dout
);

    // The lower half of the widened vector catches exactly the bits that fall off.
    logic [2*MW-1:0] wide;

    always_comb begin
        wide    = {din, {MW{1'b0}}} >> shamt;
        dout    = wide[2*MW-1:MW];
        dout[0] = wide[MW] | (|wide[MW-1:0]);
    end

endmodule

// File: rtl/fpu_addsub_seq.sv
// rtl/fpu_addsub_seq.sv - multi-cycle FP32 add/subtract engine (align, add, normalize, round)
// Purpose: accepts one operand pair at a time, walks it through an explicit FSM and
//          holds the result plus overflow/underflow flags until the consumer takes it.
// Ports:   i_clk, i_rst_n          - clock, synchronous active-low reset
//          i_valid/o_ready         - operand handshake (o_ready high only in IDLE)
//          i_a, i_b, i_aos         - operands, 0 = A+B, 1 = A-B
//          o_valid/i_ready         - result handshake
//          o_result, o_ov_fl, o_un_fl - FP32 result and flags, valid with o_valid
//          o_busy                  - engine not idle
module fpu_addsub_seq
    import fpu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_aos,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic        o_ov_fl,
    output logic        o_un_fl,
    output logic        o_busy
);

    localparam int SB = EXP_W + FRAC_W;   // sign bit position

    state_t         state;
    logic [31:0]    a_reg, b_reg;
    logic           aos_reg;
    logic           res_sign, eff_sub;
    logic [9:0]     exp_r;                // wide enough to see 255 after increments
    logic [MW-1:0]  mant_a, mant_b, mant;
    logic [4:0]     norm_cnt;

    assign o_ready = (state == S_IDLE);
    assign o_busy  = (state != S_IDLE);

    // ---------------- ALIGN datapath ----------------
    logic                 sign_b_eff, eff_sub_c, a_ge_b;
    logic [SB-1:0]        big_mag, small_mag;
    logic [EXP_W-1:0]     big_exp, small_exp, exp_diff;
    logic [4:0]           shamt;
    logic [MW-1:0]        big_mant, small_mant, small_shifted;
    logic                 a_max, b_max, a_nan, b_nan, a_inf, b_inf, special;
    logic [31:0]          spec_result;

    always_comb begin
        sign_b_eff = b_reg[SB] ^ aos_reg;
        eff_sub_c  = a_reg[SB] ^ b_reg[SB] ^ aos_reg;
        // Magnitude compare on {exp,frac} is a plain unsigned compare for FP.
        a_ge_b     = a_reg[SB-1:0] >= b_reg[SB-1:0];
        big_mag    = a_ge_b ? a_reg[SB-1:0] : b_reg[SB-1:0];
        small_mag  = a_ge_b ? b_reg[SB-1:0] : a_reg[SB-1:0];
        big_exp    = big_mag[SB-1:FRAC_W];
        small_exp  = small_mag[SB-1:FRAC_W];
        exp_diff   = big_exp - small_exp;
        shamt      = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
        big_mant   = {1'b0, big_exp != '0, big_mag[FRAC_W-1:0], {GRS_W{1'b0}}};
        small_mant = {1'b0, small_exp != '0, small_mag[FRAC_W-1:0], {GRS_W{1'b0}}};

        a_max = (a_reg[SB-1:FRAC_W] == EXP_MAX);
        b_max = (b_reg[SB-1:FRAC_W] == EXP_MAX);
        a_nan = a_max & (|a_reg[FRAC_W-1:0]);
        b_nan = b_max & (|b_reg[FRAC_W-1:0]);
        a_inf = a_max & ~(|a_reg[FRAC_W-1:0]);
        b_inf = b_max & ~(|b_reg[FRAC_W-1:0]);
        special = a_max | b_max;
        if (a_nan | b_nan | (a_inf & b_inf & eff_sub_c)) begin
            spec_result = QNAN;
        end else if (a_inf) begin
            spec_result = signed_inf(a_reg[SB]);
        end else begin
            spec_result = signed_inf(sign_b_eff);
        end
    end

    fpu_align_shift u_align (
        .din   (small_mant),
        .shamt (shamt),
        .dout  (small_shifted)
    );

    // ---------------- ROUND datapath ----------------
    logic                  rnd_up;
    logic [MW-GRS_W-1:0]   rounded;      // hidden+fraction plus one carry bit
    logic [9:0]            round_exp;
    logic [FRAC_W-1:0]     round_frac;

    always_comb begin
        // Nearest-even: round up above half, or at exactly half when the LSB is odd.
        rnd_up     = mant[2] & (mant[1] | mant[0] | mant[3]);
        rounded    = {1'b0, mant[MW-2:GRS_W]} + {{(MW-GRS_W-1){1'b0}}, rnd_up};
        round_exp  = exp_r + {9'b0, rounded[MW-GRS_W-1]};
        round_frac = rounded[MW-GRS_W-1] ? rounded[FRAC_W:1] : rounded[FRAC_W-1:0];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_ov_fl  <= 1'b0;
            o_un_fl  <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            aos_reg  <= 1'b0;
            res_sign <= 1'b0;
            eff_sub  <= 1'b0;
            exp_r    <= '0;
            mant_a   <= '0;
            mant_b   <= '0;
            mant     <= '0;
            norm_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        a_reg    <= flush_denorm(i_a);
                        b_reg    <= flush_denorm(i_b);
                        aos_reg  <= i_aos;
                        norm_cnt <= '0;
                        state    <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (special) begin
                        o_result <= spec_result;
                        o_ov_fl  <= 1'b0;
                        o_un_fl  <= 1'b0;
                        state    <= S_HOLD;
                    end else begin
                        mant_a   <= big_mant;
                        mant_b   <= small_shifted;
                        exp_r    <= {2'b0, big_exp};
                        res_sign <= a_ge_b ? a_reg[SB] : sign_b_eff;
                        eff_sub  <= eff_sub_c;
                        state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    // |A| >= |B| after the swap, so subtraction never goes negative.
                    mant  <= eff_sub ? (mant_a - mant_b) : (mant_a + mant_b);
                    state <= S_NORM;
                end
                S_NORM: begin
                    if (mant[MW-1]) begin
                        mant  <= {1'b0, mant[MW-1:2], mant[1] | mant[0]};
                        exp_r <= exp_r + 10'd1;
                        state <= S_ROUND;
                    end else if (mant == '0) begin
                        o_result <= '0;
                        o_ov_fl  <= 1'b0;
                        o_un_fl  <= 1'b0;
                        state    <= S_HOLD;
                    end else if (mant[MW-2]) begin
                        state <= S_ROUND;
                    end else if (exp_r <= 10'd1) begin
                        // Another left shift would need exponent 0: no denormal output.
                        o_result <= {res_sign, 31'b0};
                        o_ov_fl  <= 1'b0;
                        o_un_fl  <= 1'b1;
                        state    <= S_HOLD;
                    end else begin
                        mant     <= mant << 1;
                        exp_r    <= exp_r - 10'd1;
                        norm_cnt <= norm_cnt + 5'd1;
                    end
                end
                S_ROUND: begin
                    if (round_exp >= {2'b0, EXP_MAX}) begin
                        o_result <= signed_inf(res_sign);
                        o_ov_fl  <= 1'b1;
                    end else begin
                        o_result <= {res_sign, round_exp[EXP_W-1:0], round_frac};
                        o_ov_fl  <= 1'b0;
                    end
                    o_un_fl <= 1'b0;
                    state   <= S_HOLD;
                end
                S_HOLD: begin
                    // o_valid lags HOLD entry by one cycle; result regs are already stable.
                    if (!o_valid) begin
                        o_valid <= 1'b1;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A nonzero mantissa never needs more than 26 left shifts to reach the hidden bit.
    norm_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n) norm_cnt <= 5'd26);

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb/tb_fpu_addsub_seq.sv - directed self-checking bench for fpu_addsub_seq
module tb_fpu_addsub_seq;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_valid, i_aos, i_ready;
    logic [31:0] i_a, i_b;
    logic        o_ready, o_valid, o_ov_fl, o_un_fl, o_busy;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    fpu_addsub_seq dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_aos    (i_aos),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_ov_fl  (o_ov_fl),
        .o_un_fl  (o_un_fl),
        .o_busy   (o_busy)
    );

    // Called #1 after a rising edge with the engine idle. lat = rising edges from accept to o_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic aos,
                          output logic [31:0] res, output logic ov, output logic un,
                          output int lat);
        i_a = a; i_b = b; i_aos = aos; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 60) begin
            @(posedge i_clk); #1;
            lat++;
        end
        res = o_result; ov = o_ov_fl; un = o_un_fl;
        if (i_ready) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_aos = 1'b0; i_a = '0; i_b = '0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", o_result); end
        checks++; if ({o_ov_fl, o_un_fl} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {o_ov_fl, o_un_fl}); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_add_carry();
        logic [31:0] r; logic ov, un; int lat;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, r, ov, un, lat);
        checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL add_carry_result: got %h expected 40000000", r); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL add_carry_latency: got %0d expected 5", lat); end
        checks++; if ({ov, un} !== 2'b00) begin errors++; $display("FAIL add_carry_flags: got %b expected 00", {ov, un}); end
    endtask

    task automatic test_sub_norm();
        logic [31:0] r; logic ov, un; int lat;
        run_op(32'h3F800000, 32'h3F400000, 1'b1, r, ov, un, lat);
        checks++; if (r !== 32'h3E800000) begin errors++; $display("FAIL sub_norm_result: got %h expected 3E800000", r); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL sub_norm_latency: got %0d expected 7", lat); end
    endtask

    task automatic test_overflow();
        logic [31:0] r; logic ov, un; int lat;
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r, ov, un, lat);
        checks++; if (r !== 32'h7F800000) begin errors++; $display("FAIL overflow_result: got %h expected 7F800000", r); end
        checks++; if ({ov, un} !== 2'b10) begin errors++; $display("FAIL overflow_flags: got %b expected 10", {ov, un}); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL overflow_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_special();
        logic [31:0] r; logic ov, un; int lat;
        run_op(32'h7F800000, 32'h7F800000, 1'b1, r, ov, un, lat);
        checks++; if (r !== 32'h7FC00000) begin errors++; $display("FAIL inf_minus_inf_result: got %h expected 7FC00000", r); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL inf_minus_inf_latency: got %0d expected 2", lat); end
        checks++; if ({ov, un} !== 2'b00) begin errors++; $display("FAIL inf_minus_inf_flags: got %b expected 00", {ov, un}); end
        run_op(32'h3F800000, 32'h7F800000, 1'b1, r, ov, un, lat);
        checks++; if (r !== 32'hFF800000) begin errors++; $display("FAIL one_minus_inf_result: got %h expected FF800000", r); end
        run_op(32'h7FC12345, 32'h3F800000, 1'b0, r, ov, un, lat);
        checks++; if (r !== 32'h7FC00000) begin errors++; $display("FAIL nan_plus_one_result: got %h expected 7FC00000", r); end
    endtask

    task automatic test_underflow_cancel();
        logic [31:0] r; logic ov, un; int lat;
        run_op(32'h00800000, 32'h00800001, 1'b1, r, ov, un, lat);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL underflow_result: got %h expected 80000000", r); end
        checks++; if ({ov, un} !== 2'b01) begin errors++; $display("FAIL underflow_flags: got %b expected 01", {ov, un}); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL underflow_latency: got %0d expected 4", lat); end
        run_op(32'h40400000, 32'h40400000, 1'b1, r, ov, un, lat);
        checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL cancel_result: got %h expected 00000000", r); end
        checks++; if ({ov, un} !== 2'b00) begin errors++; $display("FAIL cancel_flags: got %b expected 00", {ov, un}); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL cancel_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_round_flush();
        logic [31:0] r; logic ov, un; int lat;
        // 1 + 2^-24 is an exact tie with an even LSB: stays 1.0
        run_op(32'h3F800000, 32'h33800000, 1'b0, r, ov, un, lat);
        checks++; if (r !== 32'h3F800000) begin errors++; $display("FAIL round_tie_even: got %h expected 3F800000", r); end
        // 1 + 1.5*2^-24 is above half: rounds up one ulp
        run_op(32'h3F800000, 32'h33C00000, 1'b0, r, ov, un, lat);
        checks++; if (r !== 32'h3F800001) begin errors++; $display("FAIL round_up: got %h expected 3F800001", r); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL round_latency: got %0d expected 5", lat); end
        // denormal A is flushed to -0
        run_op(32'h80400000, 32'h3F800000, 1'b0, r, ov, un, lat);
        checks++; if (r !== 32'h3F800000) begin errors++; $display("FAIL denorm_flush: got %h expected 3F800000", r); end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic ov, un; int lat;
        i_ready = 1'b0;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, r, ov, un, lat);
        checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL bp_result: got %h expected 40000000", r); end
        i_a = 32'h40400000; i_b = 32'h40400000; i_aos = 1'b1; i_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clk); #1;
            checks++;
            if ({o_valid, o_ready, o_ov_fl, o_un_fl, o_result} !== {4'b1000, 32'h40000000}) begin
                errors++;
                $display("FAIL bp_hold_cycle%0d: got valid=%b ready=%b ov=%b un=%b result=%h expected valid=1 ready=0 ov=0 un=0 result=40000000",
                         c, o_valid, o_ready, o_ov_fl, o_un_fl, o_result);
            end
        end
        i_valid = 1'b0; i_ready = 1'b1;
        @(posedge i_clk); #1;
        checks++; if ({o_ready, o_valid} !== 2'b10) begin errors++; $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", o_ready, o_valid); end
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bp_no_accept: got busy=%b expected 0", o_busy); end
    endtask

    task automatic test_reset_mid_norm();
        logic [31:0] r; logic ov, un; int lat; logic saw;
        i_ready = 1'b1;
        i_a = 32'h3F800000; i_b = 32'h3F400000; i_aos = 1'b1; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b expected 1", o_busy); end
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        checks++; if ({o_busy, o_ready, o_valid} !== 3'b010) begin errors++; $display("FAIL rst_mid_idle: got busy=%b ready=%b valid=%b expected 0 1 0", o_busy, o_ready, o_valid); end
        saw = 1'b0;
        repeat (10) begin
            @(posedge i_clk); #1;
            if (o_valid) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rst_mid_no_valid: got %b expected 0", saw); end
        run_op(32'h3F800000, 32'h3F800000, 1'b0, r, ov, un, lat);
        checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL rst_mid_after_result: got %h expected 40000000", r); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL rst_mid_after_latency: got %0d expected 5", lat); end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub_norm();
        test_overflow();
        test_special();
        test_underflow_cancel();
        test_round_flush();
        test_backpressure();
        test_reset_mid_norm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_addsub_seq.md
Name: fpu_addsub_seq

Overview:
- Multi-cycle FP32 (IEEE-754 single) add/subtract engine built around an explicit FSM.
- Sequences the align, add, iterative normalize and round stages.
- Valid/ready handshake on both the operand side and the result side.
- Sits between the FPU issue logic and the result writeback. Reports overflow/underflow flags alongside the result.

Parameters:
- EXP_W, 8, exponent width
- FRAC_W, 23, stored fraction width
- GRS_W, 3, guard/round/sticky bits; internal mantissa width MW = FRAC_W+2+GRS_W = 28

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_valid  in  1  operand pair valid
- o_ready  out  1  engine can accept operands (high only in IDLE)
- i_a  in  32  operand A
- i_b  in  32  operand B
- i_aos  in  1  0 = A+B, 1 = A-B
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_result  out  32  FP32 result
- o_ov_fl  out  1  overflow flag, valid with o_valid
- o_un_fl  out  1  underflow flag, valid with o_valid
- o_busy  out  1  state != IDLE

Behaviour:
- One clock (i_clk); reset is synchronous, active-low (i_rst_n), applied on the i_clk edge.
- Reset values: state = IDLE, o_valid = 0, o_result = 0, o_ov_fl = 0, o_un_fl = 0, o_busy = 0, o_ready = 1 (combinational: state == IDLE).
- Reset mid-operation aborts the operation; no o_valid is produced.
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, HOLD.
- IDLE:
  - On i_valid & o_ready, register i_a, i_b, i_aos; go to ALIGN.
  - Denormal inputs (exp == 0) are flushed to signed zero at capture.
- ALIGN (1 cycle):
  - Special bypass: if either exp == 255, go directly to HOLD with:
    - 0x7FC00000 for a NaN input or effective inf-inf;
    - otherwise correctly signed inf;
    - flags 0.
  - Otherwise swap operands so |A| >= |B|.
  - Shift B's mantissa right by min(expA-expB, 27); the sticky bit is the OR of all bits shifted out.
- ADD (1 cycle):
  - Effective subtract = sign(A) xor sign(B) xor i_aos.
  - 28-bit add/sub; capture the carry-out.
  - Result sign = sign of the larger operand (B's sign inverted when i_aos = 1).
- NORM (one step per cycle):
  - If carry: shift right 1 with sticky preserved, exp+1, go to ROUND.
  - Else if mantissa == 0 (exact cancellation): result +0, go to HOLD.
  - Else if hidden bit set: go to ROUND.
  - Else shift left 1, exp-1, stay in NORM.
  - If exp reaches 0 before the hidden bit is set: signed zero, o_un_fl = 1, go to HOLD.
  - Iteration counter is bounded at 26; reaching 27 is an assertion failure.
- ROUND (1 cycle):
  - Round-to-nearest-even on GRS.
  - A rounding carry renormalizes (shift right, exp+1).
  - exp == 255 after NORM or ROUND gives signed inf, o_ov_fl = 1.
- HOLD:
  - o_valid = 1; o_result and flags stay stable until i_ready.
  - On handshake go to IDLE; no same-cycle re-accept.
- Latency: o_valid rises 5+k cycles after the accept edge, where k = number of left-shift cycles. Special-operand bypass latency is 2.
- i_valid while o_ready = 0 is ignored; the upstream must hold its operands.

Decomposition:
- Package fpu_pkg:
  - FSM state enum
  - EXP_W, FRAC_W, GRS_W, MW
  - EXP_MAX = 255
  - QNAN = 0x7FC00000
  - POS_INF / NEG_INF constants
- One sub-module: fpu_align_shift, a combinational right barrel shifter with sticky generation, used in ALIGN.

Test Plan:
- 0x3F800000 + 0x3F800000 -> 0x40000000; carry path; o_valid 5 cycles after accept; flags 0.
- 0x3F800000 - 0x3F400000 -> 0x3E800000; k = 2; o_valid 7 cycles after accept.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, o_ov_fl = 1; 0x7F800000 - 0x7F800000 -> 0x7FC00000 with latency 2.
- 0x00800000 - 0x00800001 -> 0x80000000, o_un_fl = 1; 0x40400000 - 0x40400000 -> 0x00000000, flags 0.
- Backpressure: i_ready low for 10 cycles in HOLD -> o_result and flags constant, o_ready = 0, new i_valid ignored; i_ready high -> o_ready = 1 on the next cycle.
- i_rst_n low for 1 cycle while in NORM (during the 0x3F800000 - 0x3F400000 case) -> IDLE next cycle, no o_valid; a following 1.0 + 1.0 completes normally.
